fd_ratio_ctrl: RTL and testbench
================================

FD_RATIO_CTRL -- requirements
Module: fd_ratio_ctrl

Interface
REQ-001 SHALL have parameter RESET_M, default 2'd2: divide ratio driven on M_out after reset.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: cycles the divider is held gated after a ratio switch (legal range 1..15).
REQ-003 SHALL have port CLK_exit, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: ratio-change request, level, held by requester until ack.
REQ-006 SHALL have port M_req, input, 2: requested divide ratio, valid while req high.
REQ-007 SHALL have port M_out, output, 2: divide ratio driven to the divider.
REQ-008 SHALL have port div_rst_n, output, 1: active-low reset to the divider.
REQ-009 SHALL have port div_gate, output, 1: 1 = divider output enabled downstream, 0 = gated low.
REQ-010 SHALL have port ack, output, 1: one-cycle pulse, request completed.
REQ-011 SHALL have port err, output, 1: one-cycle pulse, request rejected.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port phase, output, 2: shadow of divider rising-edge counter.

Function
REQ-014 phase SHALL count 0..M_out-1 and wrap to 0; phase SHALL be held at 0 while div_rst_n=0 or M_out=1.
REQ-015 FSM states SHALL be IDLE, ALIGN, GATE, SETTLE, ACK, WAITLO; all transitions registered.
REQ-016 IDLE: on req=1, M_req SHALL be captured into an internal register; later M_req changes SHALL be ignored until return to IDLE.
REQ-017 IDLE, captured M=0: next state WAITLO, err=1 for exactly that cycle, M_out unchanged.
REQ-018 IDLE, captured M=M_out: next state ACK, no gating and no divider reset.
REQ-019 IDLE, otherwise: next state ALIGN.
REQ-020 ALIGN: remain until phase=M_out-1; on that cycle div_gate<=0 and next state GATE.
REQ-021 GATE: one cycle; M_out<=captured M, div_rst_n<=0, settle counter<=0; next state SETTLE.
REQ-022 SETTLE: div_rst_n<=1 on first cycle; settle counter increments each cycle; when it reaches SETTLE_CYC-1, div_gate<=1, phase<=0, next state ACK.
REQ-023 ACK: ack=1 for exactly one cycle; next state WAITLO.
REQ-024 WAITLO: remain while req=1; on req=0 go IDLE; no new request accepted before req has been seen low.
REQ-025 ack and err SHALL never be high together or for more than one cycle per request.
REQ-026 Latency, differing legal ratio: ack SHALL assert (distance to phase=M_out-1) + 1 (GATE) + SETTLE_CYC + 1 cycles after acceptance edge.
REQ-027 div_gate SHALL be 0 for exactly SETTLE_CYC+1 cycles per switch; M_out SHALL change only in GATE.
REQ-028 req dropping before ack SHALL NOT abort a sequence in progress; the sequence completes, ack pulses, then WAITLO exits immediately.
REQ-029 Counter widths: settle counter 4 bits, phase 2 bits; no overflow for legal parameters.

Reset
REQ-030 While rst=1: state IDLE, M_out=RESET_M, div_rst_n=0, div_gate=1, phase=0, ack=0, err=0, busy=0.
REQ-031 div_rst_n SHALL go to 1 on the first CLK_exit rising edge after rst deasserts.
REQ-032 rst asserted in any state SHALL abort immediately to reset values; the pending request is discarded with no ack.

Verification
REQ-033 Reset release, no req -> M_out=2, div_rst_n=1 after first edge, phase 0,1,0,1..., busy=0.
REQ-034 M_out=2, phase=0, req with M_req=3 -> ALIGN 2 cycles, GATE, div_gate low 5 cycles, M_out=3, ack 8 cycles after acceptance, phase then 0,1,2,0.
REQ-035 req with M_req=2 while M_out=2 -> ack next cycle, div_gate and div_rst_n never toggle.
REQ-036 req with M_req=0 -> err one cycle, M_out unchanged, no new acceptance until req low then high.
REQ-037 M_req changed 3->1 during ALIGN -> M_out becomes 3, ack once.
REQ-038 rst pulsed during SETTLE -> M_out=2, div_gate=1, no ack; fresh request after release completes normally.

Source files
------------

// File: rtl/fd_ratio_ctrl.sv
// Divide-ratio change controller: waits for the divider's last phase, gates its output,
// reloads the ratio under divider reset, lets it settle, then acknowledges the requester.
module fd_ratio_ctrl #(
    parameter logic [1:0] RESET_M    = 2'd2,
    parameter int         SETTLE_CYC = 4
) (
    input  logic       CLK_exit,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] M_req,
    output logic [1:0] M_out,
    output logic       div_rst_n,
    output logic       div_gate,
    output logic       ack,
    output logic       err,
    output logic       busy,
    output logic [1:0] phase
);

    // Handshake: req is a level held until ack or err pulses for one cycle; a new request
    // is only taken after req has been observed low again.

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        ACK    = 3'd4,
        WAITLO = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] m_cap;
    logic [3:0] settle_cnt;
    logic       align_hit;
    logic       settle_done;

    // Ratio 1 (or an out-of-range reset ratio) keeps phase at 0, so alignment is immediate.
    assign align_hit   = (M_out <= 2'd1) || (phase == (M_out - 2'd1));
    assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);

    assign ack  = (state == ACK);
    assign busy = (state != IDLE);

    // In IDLE the decision uses M_req directly; it is the same value being captured this edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (M_req == 2'd0) begin
                        state_next = WAITLO;
                    end else if (M_req == M_out) begin
                        state_next = ACK;
                    end else begin
                        state_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (align_hit) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = WAITLO;
            end
            WAITLO: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            m_cap <= 2'd0;
        end else if ((state == IDLE) && req) begin
            m_cap <= M_req;
        end
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            M_out <= RESET_M;
        end else if (state == GATE) begin
            M_out <= m_cap;
        end
    end

    // The divider is reset for exactly the first SETTLE cycle, released everywhere else.
    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            div_rst_n <= 1'b0;
        end else begin
            div_rst_n <= (state != GATE);
        end
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            div_gate <= 1'b1;
        end else if ((state == ALIGN) && align_hit) begin
            div_gate <= 1'b0;
        end else if (settle_done) begin
            div_gate <= 1'b1;
        end
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (state == GATE) begin
            settle_cnt <= 4'd0;
        end else if ((state == SETTLE) && !settle_done) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && req && (M_req == 2'd0);
        end
    end

    // Shadow of the divider's rising-edge count; restarts from 0 when the gate reopens.
    always_ff @(posedge CLK_exit or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
        end else if (settle_done || !div_rst_n || (M_out <= 2'd1)) begin
            phase <= 2'd0;
        end else if (phase == (M_out - 2'd1)) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

endmodule

// File: tb/tb_fd_ratio_ctrl.sv
// Bench for fd_ratio_ctrl: directed vector table, hand sequences for reset/abort/corner
// cases, and randomized requests checked against a transaction-level timing model.
module tb_fd_ratio_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] m_req;
    logic [1:0] m_out;
    logic       div_rst_n;
    logic       div_gate;
    logic       ack;
    logic       err;
    logic       busy;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int gate_low = 0;
    int drst_low = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Phase model: phase was 0 at edge zero_cyc and counts modulo cur_m from there.
    int cur_m    = 2;
    int zero_cyc = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        int         w;
        logic [1:0] m;
        int         is_err;
        int         lat;
        logic [1:0] m_after;
        int         gate_low;
        int         drst_low;
    } vec_t;

    vec_t vecs[7];

    fd_ratio_ctrl #(
        .RESET_M    (2'd2),
        .SETTLE_CYC (S)
    ) dut (
        .CLK_exit  (clk),
        .rst       (rst),
        .req       (req),
        .M_req     (m_req),
        .M_out     (m_out),
        .div_rst_n (div_rst_n),
        .div_gate  (div_gate),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (!div_gate) gate_low++;
        if (!div_rst_n) drst_low++;
        if (ack) ack_cnt++;
        if (err) err_cnt++;
        if (ack && err) both_cnt++;
    endtask

    function automatic int exp_phase(input int c);
        if (cur_m <= 1) return 0;
        return (c - zero_cyc) % cur_m;
    endfunction

    task automatic do_reset();
        req   = 1'b0;
        m_req = 2'd0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        cur_m    = 2;
        zero_cyc = cyc;
    endtask

    task automatic start_req(input logic [1:0] m);
        m_req    = m;
        req      = 1'b1;
        gate_low = 0;
        drst_low = 0;
        ack_cnt  = 0;
        err_cnt  = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (ack || err) begin
                lat = i;
                break;
            end
        end
        chk("done_within_budget", int'(lat != 0), 1);
    endtask

    initial begin
        int lat;
        int gap;
        int c0;
        int p;
        int a;
        int exp_lat;
        int exp_err;
        int exp_gate;
        int exp_drst;
        logic [1:0] m;
        logic [1:0] m_exp;

        rst   = 1'b1;
        req   = 1'b0;
        m_req = 2'd0;

        //        w  m     err lat m_after gate drst
        vecs[0] = '{0, 2'd3, 0, 7, 2'd3, 5, 1};
        vecs[1] = '{1, 2'd3, 0, 8, 2'd3, 5, 1};
        vecs[2] = '{1, 2'd1, 0, 8, 2'd1, 5, 1};
        vecs[3] = '{0, 2'd1, 0, 7, 2'd1, 5, 1};
        vecs[4] = '{0, 2'd2, 0, 1, 2'd2, 0, 0};
        vecs[5] = '{2, 2'd0, 1, 1, 2'd2, 0, 0};
        vecs[6] = '{5, 2'd3, 0, 8, 2'd3, 5, 1};

        // Reset values and free-running phase after release.
        tick();
        tick();
        chk("rst_m_out", m_out, 2);
        chk("rst_div_rst_n", div_rst_n, 0);
        chk("rst_div_gate", div_gate, 1);
        chk("rst_phase", phase, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("rel_div_rst_n", div_rst_n, 1);
        chk("rel_phase0", phase, 0);
        tick();
        chk("rel_phase1", phase, 1);
        tick();
        chk("rel_phase2", phase, 0);
        tick();
        chk("rel_phase3", phase, 1);
        chk("rel_busy", busy, 0);

        // Directed vector table, each row from a fresh reset.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            repeat (vecs[i].w) tick();
            start_req(vecs[i].m);
            wait_done(lat);
            chk("vec_lat", lat, vecs[i].lat);
            chk("vec_err", err, vecs[i].is_err);
            chk("vec_ack", ack, 1 - vecs[i].is_err);
            chk("vec_m_out", m_out, vecs[i].m_after);
            chk("vec_gate_low", gate_low, vecs[i].gate_low);
            chk("vec_drst_low", drst_low, vecs[i].drst_low);
            if (vecs[i].gate_low > 0) begin
                chk("vec_phase_at_ack", phase, 0);
                tick();
                tick();
                chk("vec_phase_after", phase,
                    (vecs[i].m_after > 1) ? (2 % vecs[i].m_after) : 0);
            end
            req = 1'b0;
            tick();
            tick();
            chk("vec_busy_after", busy, 0);
            chk("vec_single_pulse", ack_cnt + err_cnt, 1);
        end

        // Rejected request: no new acceptance until req is seen low.
        do_reset();
        start_req(2'd0);
        wait_done(lat);
        chk("rej_err", err, 1);
        m_req = 2'd3;
        repeat (5) tick();
        chk("rej_busy_held", busy, 1);
        chk("rej_no_ack", ack_cnt, 0);
        chk("rej_m_out", m_out, 2);
        req = 1'b0;
        tick();
        tick();
        chk("rej_idle", busy, 0);
        start_req(2'd3);
        wait_done(lat);
        chk("rej_retry_ack", ack, 1);
        chk("rej_retry_m_out", m_out, 3);
        req = 1'b0;
        tick();

        // M_req change during ALIGN is ignored.
        do_reset();
        tick();
        start_req(2'd3);
        tick();
        m_req = 2'd1;
        wait_done(lat);
        chk("chg_ack", ack, 1);
        chk("chg_m_out", m_out, 3);
        req = 1'b0;
        repeat (3) tick();
        chk("chg_ack_once", ack_cnt, 1);

        // req dropped before ack: sequence completes, WAITLO exits at once.
        do_reset();
        start_req(2'd1);
        tick();
        tick();
        req = 1'b0;
        wait_done(lat);
        chk("drop_ack", ack, 1);
        chk("drop_m_out", m_out, 1);
        tick();
        tick();
        chk("drop_idle", busy, 0);

        // Reset during SETTLE aborts; a fresh request then completes.
        do_reset();
        tick();
        start_req(2'd3);
        repeat (4) tick();
        chk("abort_in_settle", div_gate, 0);
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("abort_m_out", m_out, 2);
        chk("abort_gate", div_gate, 1);
        chk("abort_busy", busy, 0);
        chk("abort_div_rst_n", div_rst_n, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_no_ack", ack_cnt, 0);
        start_req(2'd1);
        wait_done(lat);
        chk("abort_fresh_ack", ack, 1);
        chk("abort_fresh_m_out", m_out, 1);
        req = 1'b0;
        tick();

        // Randomized requests against the timing model.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(2, 5);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rand_idle_phase", phase, exp_phase(cyc));
            end
            m  = 2'($urandom_range(0, 3));
            c0 = cyc + 1;
            p  = exp_phase(c0);
            if (m == 2'd0) begin
                exp_err = 1; exp_lat = 1; exp_gate = 0; exp_drst = 0;
                m_exp = 2'(cur_m);
            end else if (int'(m) == cur_m) begin
                exp_err = 0; exp_lat = 1; exp_gate = 0; exp_drst = 0;
                m_exp = m;
            end else begin
                a = ((cur_m - 1 - p + cur_m) % cur_m) + 1;
                exp_err = 0; exp_lat = a + S + 2; exp_gate = S + 1; exp_drst = 1;
                m_exp = m;
            end
            exp_q.push_back(m_exp);
            start_req(m);
            wait_done(lat);
            chk("rand_lat", lat, exp_lat);
            chk("rand_err", err, exp_err);
            chk("rand_m_out", m_out, exp_q.pop_front());
            chk("rand_gate_low", gate_low, exp_gate);
            chk("rand_drst_low", drst_low, exp_drst);
            if (exp_gate > 0) begin
                zero_cyc = c0 + exp_lat - 1;
                cur_m    = int'(m);
            end
            req = 1'b0;
            tick();
            chk("rand_single_pulse", ack_cnt + err_cnt, 1);
            chk("rand_post_phase", phase, exp_phase(cyc));
        end

        chk("ack_err_overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
